tft_funcmod: RTL and testbench

Bus-level responder for the TFT controller's call interface: accepts one-hot-priority calls (register write, command write, data write), latches the 8-bit register index and 16-bit data, and drives the 8080-style 16-bit parallel write bus of the SSD2119-class panel with programmable WR timing. It returns a one-cycle done pulse per completed call. It sits between the TFT control module (the initiator) and the panel pins.

---
 rtl/tft_pkg.sv | 29 ++
 rtl/tft_funcmod.sv | 140 ++++++++++++++
 tb/tb_tft_funcmod.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT controller and its bus-level responder:
// call-bit positions, FSM/phase encodings and SSD2119 register indices.
package tft_pkg;

  localparam int CALL_REG = 2;
  localparam int CALL_CMD = 1;
  localparam int CALL_DAT = 0;

  localparam logic [7:0] REG_RAM_DATA = 8'h22;
  localparam logic [7:0] REG_X_ADDR   = 8'h4E;
  localparam logic [7:0] REG_Y_ADDR   = 8'h4F;

  typedef enum logic [2:0] {IDLE, SETUP, WRL, WRH, DONE} state_e;
  typedef enum logic {INDEX, DATA} phase_e;
  typedef enum logic [1:0] {KIND_DAT, KIND_CMD, KIND_REG} kind_e;

  // Highest set call bit wins; an all-zero call is never latched.
  function automatic kind_e call_kind(input logic [2:0] call);
    if (call[CALL_REG])      return KIND_REG;
    else if (call[CALL_CMD]) return KIND_CMD;
    else                     return KIND_DAT;
  endfunction

  function automatic logic [15:0] bus_word(input phase_e ph, input logic [7:0] addr,
                                           input logic [15:0] data);
    return (ph == INDEX) ? {8'h00, addr} : data;
  endfunction

endpackage

// File: rtl/tft_funcmod.sv
// 8080-style write-only bus responder: one call in, one or two WR strobes out
// on the panel bus, then a single-cycle done pulse back to the initiator.
module tft_funcmod
  import tft_pkg::*;
#(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [2:0]  iCall,
  input  logic [7:0]  iAddr,
  input  logic [15:0] iData,
  output logic        oDone,
  output logic        TFT_CS,
  output logic        TFT_RS,
  output logic        TFT_WR,
  output logic        TFT_RD,
  output logic [15:0] TFT_DB
);

  localparam logic [3:0] LOW_LOAD  = 4'(WR_LOW - 1);
  localparam logic [3:0] HIGH_LOAD = 4'(WR_HIGH - 1);

  state_e      state_reg, state_next;
  phase_e      phase_reg, phase_next;
  kind_e       kind_reg, kind_next;
  logic [3:0]  count_reg, count_next;
  logic [7:0]  addr_reg, addr_next;
  logic [15:0] data_reg, data_next;
  logic        done_reg, done_next;
  logic        cs_reg, cs_next;
  logic        rs_reg, rs_next;
  logic        wr_reg, wr_next;
  logic [15:0] db_reg, db_next;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= IDLE;
      phase_reg <= INDEX;
      kind_reg  <= KIND_DAT;
      count_reg <= 4'd0;
      addr_reg  <= 8'h00;
      data_reg  <= 16'h0000;
      done_reg  <= 1'b0;
      cs_reg    <= 1'b1;
      rs_reg    <= 1'b1;
      wr_reg    <= 1'b1;
      db_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      kind_reg  <= kind_next;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      cs_reg    <= cs_next;
      rs_reg    <= rs_next;
      wr_reg    <= wr_next;
      db_reg    <= db_next;
    end
  end

  // Outputs are set on the transition into each state so the pins are
  // registered and line up exactly with the state they belong to.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    kind_next  = kind_reg;
    count_next = count_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    cs_next    = cs_reg;
    rs_next    = rs_reg;
    wr_next    = wr_reg;
    db_next    = db_reg;

    case (state_reg)
      IDLE: begin
        if (|iCall) begin
          kind_next  = call_kind(iCall);
          phase_next = (call_kind(iCall) == KIND_DAT) ? DATA : INDEX;
          addr_next  = iAddr;
          data_next  = iData;
          state_next = SETUP;
          cs_next    = 1'b0;
          wr_next    = 1'b1;
          rs_next    = (phase_next == DATA);
          db_next    = bus_word(phase_next, iAddr, iData);
        end
      end
      SETUP: begin
        state_next = WRL;
        wr_next    = 1'b0;
        count_next = LOW_LOAD;
      end
      WRL: begin
        if (count_reg == 4'd0) begin
          state_next = WRH;
          wr_next    = 1'b1;
          count_next = HIGH_LOAD;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      WRH: begin
        if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else if (kind_reg == KIND_REG && phase_reg == INDEX) begin
          // Second half of a register write: CS stays low across the index/data pair.
          state_next = SETUP;
          phase_next = DATA;
          rs_next    = 1'b1;
          db_next    = data_reg;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
          cs_next    = 1'b1;
          rs_next    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign oDone  = done_reg;
  assign TFT_CS = cs_reg;
  assign TFT_RS = rs_reg;
  assign TFT_WR = wr_reg;
  assign TFT_RD = 1'b1;
  assign TFT_DB = db_reg;

endmodule

// File: tb/tb_tft_funcmod.sv
// Scoreboard bench for tft_funcmod: the driver queues expected bus writes and
// done cycles, and a negedge monitor pops and compares them as the DUT presents them.
module tb_tft_funcmod;

  localparam int WR_LOW  = 2;
  localparam int WR_HIGH = 2;
  localparam int PERIOD_SINGLE = 1 + WR_LOW + WR_HIGH;
  localparam int PERIOD_REG    = 2 + 2 * WR_LOW + 2 * WR_HIGH;
  localparam int PERIOD_PIXEL  = PERIOD_SINGLE + 2;

  logic        clk = 1'b0;
  logic        srst;
  logic [2:0]  call;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        done;
  logic        tft_cs, tft_rs, tft_wr, tft_rd;
  logic [15:0] tft_db;

  tft_funcmod #(.WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH)) dut (
    .CLOCK (clk),
    .RESET (srst),
    .iCall (call),
    .iAddr (addr),
    .iData (data),
    .oDone (done),
    .TFT_CS(tft_cs),
    .TFT_RS(tft_rs),
    .TFT_WR(tft_wr),
    .TFT_RD(tft_rd),
    .TFT_DB(tft_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] wr_q[$];    // {rs, db} expected at each WR rising edge
  int          done_q[$];  // cycle index at which oDone is expected
  logic        abort = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every WR rising edge and every oDone pulse with the scoreboard.
  initial begin
    logic wr_prev = 1'b1;
    int   low_len = 0;
    logic [16:0] exp_wr;
    int   exp_cyc;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (done_q.size() == 0) fail_now("done_unexpected");
        else begin
          exp_cyc = done_q.pop_front();
          check("done_cycle", cyc, exp_cyc);
          $display("done at cycle %0d", cyc);
        end
      end
      if (abort || srst) begin
        low_len = 0;
      end else if (tft_wr === 1'b0) begin
        low_len++;
        if (wr_prev === 1'b1) check("cs_at_wr_fall", int'(tft_cs), 0);
      end else if (wr_prev === 1'b0) begin
        check("wr_low_len", low_len, WR_LOW);
        check("cs_at_wr_rise", int'(tft_cs), 0);
        if (wr_q.size() == 0) fail_now("write_unexpected");
        else begin
          exp_wr = wr_q.pop_front();
          check("write_rs", int'(tft_rs), int'(exp_wr[16]));
          check("write_db", int'(tft_db), int'(exp_wr[15:0]));
        end
        $display("write rs=%b db=%h", tft_rs, tft_db);
        low_len = 0;
      end
      wr_prev = tft_wr;
    end
  end

  // Returns at the negedge where oDone is seen, or flags a timeout.
  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) fail_now("done_timeout");
  endtask

  // Issues a call at the current negedge and holds it until oDone, then drops it.
  task automatic single_call(input logic [2:0] c, input logic [7:0] a, input logic [15:0] d);
    int e0;
    e0 = cyc + 1;
    if (c[2]) begin
      wr_q.push_back({1'b0, 8'h00, a});
      wr_q.push_back({1'b1, d});
      done_q.push_back(e0 + PERIOD_REG);
    end else begin
      wr_q.push_back(c[1] ? {1'b0, 8'h00, a} : {1'b1, d});
      done_q.push_back(e0 + PERIOD_SINGLE);
    end
    call = c; addr = a; data = d;
    wait_done(60);
    call = 3'b000;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int e0;
    srst = 1'b1; call = 3'b000; addr = 8'h00; data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;

    // Reset state
    check("rst_cs", int'(tft_cs), 1);
    check("rst_rs", int'(tft_rs), 1);
    check("rst_wr", int'(tft_wr), 1);
    check("rst_rd", int'(tft_rd), 1);
    check("rst_db", int'(tft_db), 0);
    check("rst_done", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_done", int'(done), 0);
      check("idle_wr", int'(tft_wr), 1);
    end

    // Register write: index 4E then data 1234
    single_call(3'b100, 8'h4E, 16'h1234);
    // Command-only write
    single_call(3'b010, 8'h22, 16'h0000);

    // 100 back-to-back pixel writes with iCall held high
    e0 = cyc + 1;
    for (int k = 0; k < 100; k++) begin
      wr_q.push_back({1'b1, 16'hFFFF});
      done_q.push_back(e0 + PERIOD_SINGLE + k * PERIOD_PIXEL);
    end
    call = 3'b001; data = 16'hFFFF; addr = 8'h00;
    for (int k = 0; k < 100; k++) begin
      wait_done(30);
      if (k == 99) call = 3'b000;
      @(negedge clk);
    end
    @(negedge clk);
    check("pixel_queue_drained", wr_q.size(), 0);

    // All call bits set: register write wins; inputs disturbed mid-transfer
    e0 = cyc + 1;
    wr_q.push_back({1'b0, 16'h004F});
    wr_q.push_back({1'b1, 16'hBEEF});
    done_q.push_back(e0 + PERIOD_REG);
    call = 3'b111; addr = 8'h4F; data = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    check("wrl_reached", int'(tft_wr), 0);
    data = 16'hDEAD; addr = 8'h00; call = 3'b001;
    wait_done(40);
    call = 3'b000;
    @(negedge clk);
    @(negedge clk);

    // Reset during WRL aborts with no done pulse
    abort = 1'b1;
    call = 3'b100; addr = 8'h4E; data = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    check("abort_wr_low", int'(tft_wr), 0);
    srst = 1'b1;
    @(negedge clk);
    check("abort_wr", int'(tft_wr), 1);
    check("abort_cs", int'(tft_cs), 1);
    check("abort_done", int'(done), 0);
    srst = 1'b0; call = 3'b000;
    repeat (4) @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    single_call(3'b001, 8'h00, 16'hA5A5);

    check("write_queue_drained", wr_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
